// File: rtl/mod_button_bank.sv
// Bank of independent debounced push-buttons with press, release
// and long-press pulses; one synchroniser and counter pair per channel.
module mod_button_bank #(
  parameter int CHANNELS     = 4,
  parameter int TIMEOUT      = 100,
  parameter int LONG_TIMEOUT = 1000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [CHANNELS-1:0] pin_i,
  output logic [CHANNELS-1:0] state_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic [CHANNELS-1:0] long_o
);

  localparam int CW = $clog2(TIMEOUT);
  localparam int HW = $clog2(LONG_TIMEOUT);

  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_TIMEOUT - 2);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic          meta;
    logic          raw;
    logic          sync;
    logic          st;
    logic          st_d;
    logic          pr;
    logic          rl;
    logic          lg;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hold;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        meta <= ACTIVE_LOW;
        raw  <= ACTIVE_LOW;
      end else begin
        meta <= pin_i[c];
        raw  <= meta;
      end
    end

    assign sync = raw ^ ACTIVE_LOW;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt <= '0;
        st  <= 1'b0;
      end else if (sync == st) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        st  <= ~st;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    // Pulses trail the level by one cycle via the delayed copy st_d.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        st_d <= 1'b0;
        pr   <= 1'b0;
        rl   <= 1'b0;
        lg   <= 1'b0;
        hold <= '0;
      end else begin
        st_d <= st;
        pr   <= st & ~st_d;
        rl   <= ~st & st_d;
        lg   <= st && (hold == HOLD_PRE);
        if (!st) begin
          hold <= '0;
        end else if (hold != HOLD_LAST) begin
          hold <= hold + 1'b1;
        end
      end
    end

    assign state_o[c]   = st;
    assign press_o[c]   = pr;
    assign release_o[c] = rl;
    assign long_o[c]    = lg;
  end

endmodule

// File: tb/tb_mod_button_bank.sv
// Randomised and directed bench for mod_button_bank with a
// per-cycle expected-output queue checked by an independent monitor.
module tb_mod_button_bank;

  localparam int CH = 4;
  localparam int TO = 4;
  localparam int LT = 10;
  localparam bit AL = 1'b1;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [CH-1:0] pin_i = '1;
  logic [CH-1:0] state_o;
  logic [CH-1:0] press_o;
  logic [CH-1:0] release_o;
  logic [CH-1:0] long_o;

  always #5 clk = ~clk;

  mod_button_bank #(
    .CHANNELS    (CH),
    .TIMEOUT     (TO),
    .LONG_TIMEOUT(LT),
    .ACTIVE_LOW  (AL)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .pin_i    (pin_i),
    .state_o  (state_o),
    .press_o  (press_o),
    .release_o(release_o),
    .long_o   (long_o)
  );

  typedef struct packed {
    logic [CH-1:0] st;
    logic [CH-1:0] pr;
    logic [CH-1:0] rl;
    logic [CH-1:0] lg;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int   n_press[CH];
  int   n_long[CH];
  int   n_rel[CH];
  bit   seen_1001 = 1'b0;

  // Reference model: synchronised sample history plus run lengths
  bit [CH-1:0] m_sh1 = '1;
  bit [CH-1:0] m_sh2 = '1;
  bit [CH-1:0] m_state = '0;
  bit [CH-1:0] m_prev = '0;
  int          m_run[CH];
  int          m_held[CH];
  bit          prev_rst = 1'b0;

  task automatic check(input string name, input logic [CH-1:0] act,
                       input logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [CH-1:0] v, input logic r);
    exp_t e;
    bit   sync;
    int   old;
    @(negedge clk);
    pin_i  = v;
    rst_ni = r;
    if (!r && prev_rst) begin
      #1;
      check("async_reset", state_o | press_o | release_o | long_o, '0);
    end
    prev_rst = r;
    e = '0;
    if (!r) begin
      m_sh1   = AL ? '1 : '0;
      m_sh2   = AL ? '1 : '0;
      m_state = '0;
      m_prev  = '0;
      for (int c = 0; c < CH; c++) begin
        m_run[c]  = 0;
        m_held[c] = 0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        sync     = m_sh2[c] ^ AL;
        e.pr[c]  = m_state[c] & ~m_prev[c];
        e.rl[c]  = ~m_state[c] & m_prev[c];
        old      = m_held[c];
        if (m_state[c])
          m_held[c] = (m_held[c] + 1 > LT - 1) ? LT - 1 : m_held[c] + 1;
        else
          m_held[c] = 0;
        e.lg[c]  = (m_held[c] == LT - 1) && (old != LT - 1);
        m_prev[c] = m_state[c];
        if (sync == m_state[c]) begin
          m_run[c] = 0;
        end else begin
          m_run[c]++;
          if (m_run[c] == TO) begin
            m_state[c] = ~m_state[c];
            m_run[c]   = 0;
          end
        end
        e.st[c] = m_state[c];
      end
      m_sh2 = m_sh1;
      m_sh1 = v;
    end
    sb.push_back(e);
  endtask

  task automatic hold_pins(input logic [CH-1:0] v, input int n);
    for (int i = 0; i < n; i++) step(v, 1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("state_o", state_o, e.st);
        check("press_o", press_o, e.pr);
        check("release_o", release_o, e.rl);
        check("long_o", long_o, e.lg);
        check("press_release_overlap", press_o & release_o, '0);
        if (press_o == 4'b1001) seen_1001 = 1'b1;
        for (int c = 0; c < CH; c++) begin
          n_press[c] += int'(press_o[c]);
          n_rel[c]   += int'(release_o[c]);
          n_long[c]  += int'(long_o[c]);
        end
      end
    end
  end

  initial begin : driver
    int p0;
    int l0;
    int r0;
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) begin
      m_run[c]   = 0;
      m_held[c]  = 0;
      n_press[c] = 0;
      n_long[c]  = 0;
      n_rel[c]   = 0;
    end

    for (int i = 0; i < 3; i++) step('1, 1'b0);
    hold_pins('1, 4);

    hold_pins(4'b1110, 10);
    hold_pins('1, 10);
    check_int("ch0_single_press", n_press[0], 1);

    p0 = n_press[1];
    r0 = n_rel[1];
    hold_pins(4'b1101, 3);
    hold_pins('1, 8);
    check_int("ch1_bounce_press", n_press[1] - p0, 0);
    check_int("ch1_bounce_release", n_rel[1] - r0, 0);

    p0 = n_press[2];
    l0 = n_long[2];
    r0 = n_rel[2];
    hold_pins(4'b1011, 20);
    hold_pins('1, 10);
    check_int("ch2_press_count", n_press[2] - p0, 1);
    check_int("ch2_long_count", n_long[2] - l0, 1);
    check_int("ch2_release_count", n_rel[2] - r0, 1);

    hold_pins(4'b0110, 8);
    hold_pins('1, 8);
    check_int("ch0_ch3_same_cycle", int'(seen_1001), 1);

    p0 = n_press[0];
    hold_pins(4'b1110, 3);
    step(4'b1110, 1'b0);
    step(4'b1110, 1'b0);
    hold_pins(4'b1110, 12);
    hold_pins('1, 10);
    check_int("ch0_press_after_reset", n_press[0] - p0, 1);

    v = '1;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 99) < 4) v[c] = ~v[c];
      step(v, ($urandom_range(0, 999) < 2) ? 1'b0 : 1'b1);
    end
    hold_pins('1, 12);

    @(posedge clk);
    #2;
    check_int("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
